// File: rtl/multi_layer_draw_engine.sv
// Per-frame pixel sequencer: buffer-state pixel, background, NUM_PLAT platforms, doodle sprite.
// Optional macro CLIP_EN suppresses platform/sprite pixels outside the background window.

module multi_layer_draw_engine #(
  parameter int COORD_W  = 10,
  parameter int COLOR_W  = 8,
  parameter int NUM_PLAT = 8,
  parameter int PLAT_W   = 11,
  parameter int PLAT_H   = 1,
  parameter int SPR_W    = 7,
  parameter int SPR_H    = 9,
  parameter int BG_X0    = 80,
  parameter int BG_X1    = 239,
  parameter int BG_Y0    = 0,
  parameter int BG_Y1    = 239,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 8'h3F,
  parameter logic [COLOR_W-1:0] PLAT_COLOR = 8'h07,
  parameter logic [COLOR_W-1:0] SPR_COLOR  = 8'h2C
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_clk,
  input  logic [COORD_W-1:0]           Doodle_X,
  input  logic [COORD_W-1:0]           Doodle_Y,
  input  logic [NUM_PLAT*COORD_W-1:0]  plat_x,
  input  logic [NUM_PLAT*COORD_W-1:0]  plat_y,
  input  logic [NUM_PLAT-1:0]          plat_en,
  input  logic                         buffer_using,
  input  logic                         wr_en,
  output logic [COORD_W-1:0]           draw_x,
  output logic [COORD_W-1:0]           draw_y,
  output logic [COLOR_W-1:0]           draw_color,
  output logic                         draw_valid,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_overrun
);

  localparam int SW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam logic [COORD_W-1:0] BG_WL = COORD_W'(BG_X1 - BG_X0);
  localparam logic [COORD_W-1:0] BG_HL = COORD_W'(BG_Y1 - BG_Y0);
  localparam logic [COORD_W-1:0] PL_WL = COORD_W'(PLAT_W - 1);
  localparam logic [COORD_W-1:0] PL_HL = COORD_W'(PLAT_H - 1);
  localparam logic [COORD_W-1:0] SP_WL = COORD_W'(SPR_W - 1);
  localparam logic [COORD_W-1:0] SP_HL = COORD_W'(SPR_H - 1);
  localparam logic [SW-1:0]      LAST_SLOT = SW'(NUM_PLAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUF  = 3'd1,
    S_BG   = 3'd2,
    S_PLAT = 3'd3,
    S_SPR  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e state_q, state_d, nxt_s;

  logic sync1_q, sync2_q, hist_q, start_s;

  logic [COORD_W-1:0]          snap_dx_q, snap_dy_q;
  logic [NUM_PLAT*COORD_W-1:0] snap_px_q, snap_py_q;
  logic [NUM_PLAT-1:0]         snap_en_q;
  logic                        snap_buf_q;

  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic               rdone_q, rdone_d;

  logic [COORD_W-1:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic [COLOR_W-1:0] draw_color_q, draw_color_d;
  logic               draw_valid_q, draw_valid_d;
  logic               busy_q, done_q, ovr_q;

  logic [COORD_W-1:0] org_x_s, org_y_s, wl_s, hl_s, px_s, py_s;
  logic [COLOR_W-1:0] col_s;
  logic               cur_en_s, adv_s, load_s, restart_s, vis_s;

  assign start_s  = sync2_q & ~hist_q;
  assign adv_s    = ~draw_valid_q | wr_en;
  assign cur_en_s = snap_en_q[slot_q];

  // Frame tick synchroniser and edge-history flop
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Snapshot of game-logic inputs taken as the frame starts
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      snap_dx_q  <= '0;
      snap_dy_q  <= '0;
      snap_px_q  <= '0;
      snap_py_q  <= '0;
      snap_en_q  <= '0;
      snap_buf_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start_s) begin
      snap_dx_q  <= Doodle_X;
      snap_dy_q  <= Doodle_Y;
      snap_px_q  <= plat_x;
      snap_py_q  <= plat_y;
      snap_en_q  <= plat_en;
      snap_buf_q <= buffer_using;
    end
  end

  // Geometry of the rectangle owned by the current state
  always_comb begin
    org_x_s = '0;
    org_y_s = '0;
    wl_s    = '0;
    hl_s    = '0;
    col_s   = '0;
    nxt_s   = S_IDLE;
    case (state_q)
      S_BUF: begin
        org_x_s = snap_buf_q ? COORD_W'(10) : COORD_W'(11);
        org_y_s = COORD_W'(10);
        col_s   = snap_buf_q ? COLOR_W'(8'h30) : COLOR_W'(8'h0C);
        nxt_s   = S_BG;
      end
      S_BG: begin
        org_x_s = COORD_W'(BG_X0);
        org_y_s = COORD_W'(BG_Y0);
        wl_s    = BG_WL;
        hl_s    = BG_HL;
        col_s   = BG_COLOR;
        nxt_s   = S_PLAT;
      end
      S_PLAT: begin
        org_x_s = snap_px_q[int'(slot_q)*COORD_W +: COORD_W];
        org_y_s = snap_py_q[int'(slot_q)*COORD_W +: COORD_W];
        wl_s    = PL_WL;
        hl_s    = PL_HL;
        col_s   = PLAT_COLOR;
        nxt_s   = S_SPR;
      end
      S_SPR: begin
        org_x_s = snap_dx_q;
        org_y_s = snap_dy_q;
        wl_s    = SP_WL;
        hl_s    = SP_HL;
        col_s   = SPR_COLOR;
        nxt_s   = S_DONE;
      end
      default: begin
        nxt_s = S_IDLE;
      end
    endcase
  end

`ifdef CLIP_EN
  // One extra bit keeps near-maximum origins from wrapping back into the window
  logic [COORD_W:0] sum_x_s, sum_y_s;
  logic             in_win_s, clip_s;
  assign sum_x_s  = {1'b0, org_x_s} + {1'b0, ox_q};
  assign sum_y_s  = {1'b0, org_y_s} + {1'b0, oy_q};
  assign in_win_s = (sum_x_s >= (COORD_W+1)'(BG_X0)) && (sum_x_s <= (COORD_W+1)'(BG_X1)) &&
                    (sum_y_s >= (COORD_W+1)'(BG_Y0)) && (sum_y_s <= (COORD_W+1)'(BG_Y1));
  assign clip_s   = (state_q == S_PLAT) || (state_q == S_SPR);
  assign px_s     = sum_x_s[COORD_W-1:0];
  assign py_s     = sum_y_s[COORD_W-1:0];
  assign vis_s    = ~clip_s | in_win_s;
`else
  assign px_s  = org_x_s + ox_q;
  assign py_s  = org_y_s + oy_q;
  assign vis_s = 1'b1;
`endif

  // Sequencer: a new pixel is loaded only when the output slot is free or transferring
  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    slot_d       = slot_q;
    rdone_d      = rdone_q;
    load_s       = 1'b0;
    restart_s    = 1'b0;
    draw_x_d     = draw_x_q;
    draw_y_d     = draw_y_q;
    draw_color_d = draw_color_q;
    draw_valid_d = draw_valid_q & ~wr_en;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d   = S_BUF;
          restart_s = 1'b1;
          slot_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUF, S_BG, S_SPR: begin
        if (adv_s && rdone_q) begin
          state_d   = nxt_s;
          restart_s = 1'b1;
        end else if (adv_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      S_PLAT: begin
        if (adv_s && (rdone_q || !cur_en_s)) begin
          restart_s = 1'b1;
          if (slot_q == LAST_SLOT) begin
            state_d = nxt_s;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end else if (adv_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (restart_s) begin
      ox_d    = '0;
      oy_d    = '0;
      rdone_d = 1'b0;
    end else if (load_s) begin
      draw_x_d     = px_s;
      draw_y_d     = py_s;
      draw_color_d = col_s;
      draw_valid_d = vis_s;
      if (ox_q == wl_s) begin
        ox_d = '0;
        if (oy_q == hl_s) begin
          rdone_d = 1'b1;
        end else begin
          oy_d = oy_q + COORD_W'(1);
        end
      end else begin
        ox_d = ox_q + COORD_W'(1);
      end
    end else begin
      rdone_d = rdone_q;
    end
  end

  // FSM state and scan counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      slot_q  <= '0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      slot_q  <= slot_d;
      rdone_q <= rdone_d;
    end
  end

  // Registered outputs; busy/frame_done track the state being entered
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      draw_color_q <= '0;
      draw_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      draw_color_q <= draw_color_d;
      draw_valid_q <= draw_valid_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      ovr_q        <= start_s & (state_q != S_IDLE);
    end
  end

  assign draw_x        = draw_x_q;
  assign draw_y        = draw_y_q;
  assign draw_color    = draw_color_q;
  assign draw_valid    = draw_valid_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_multi_layer_draw_engine.sv
// Self-checking bench: default instance for the full-size frame, a small-background
// instance for randomized stall/clip/platform frames against a rectangle-list model.

module tb_multi_layer_draw_engine;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        rst_n;
  logic        fclk_a, fclk_b, wr_a, wr_b, rand_b;
  logic [9:0]  dx_in, dy_in;
  logic [79:0] px_in, py_in;
  logic [7:0]  pen_in;
  logic        bu_in;

  logic [9:0] dxo [2];
  logic [9:0] dyo [2];
  logic [7:0] dco [2];
  logic       dv [2];
  logic       busy [2];
  logic       done [2];
  logic       ovr [2];

  multi_layer_draw_engine dut_a (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(fclk_a),
    .Doodle_X(dx_in), .Doodle_Y(dy_in), .plat_x(px_in), .plat_y(py_in),
    .plat_en(pen_in), .buffer_using(bu_in), .wr_en(wr_a),
    .draw_x(dxo[0]), .draw_y(dyo[0]), .draw_color(dco[0]), .draw_valid(dv[0]),
    .busy(busy[0]), .frame_done(done[0]), .frame_overrun(ovr[0]));

  multi_layer_draw_engine #(.BG_X0(80), .BG_X1(95), .BG_Y0(0), .BG_Y1(7)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(fclk_b),
    .Doodle_X(dx_in), .Doodle_Y(dy_in), .plat_x(px_in), .plat_y(py_in),
    .plat_en(pen_in), .buffer_using(bu_in), .wr_en(wr_b),
    .draw_x(dxo[1]), .draw_y(dyo[1]), .draw_color(dco[1]), .draw_valid(dv[1]),
    .busy(busy[1]), .frame_done(done[1]), .frame_overrun(ovr[1]));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt [2];
  int ovr_cnt  [2];
  logic        prev_stall [2];
  logic        prev_done  [2];
  logic [27:0] prev_pix   [2];
  logic [27:0] got_a[$], got_b[$], exp_q[$];
  int          st_a[$], st_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Transfer capture, stall stability and busy-after-done checks
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic wrk;
      wrk = (k == 0) ? wr_a : wr_b;
      if (!rst_n) begin
        prev_stall[k] = 1'b0;
        prev_done[k]  = 1'b0;
      end else begin
        if (prev_stall[k])
          chk($sformatf("stall_hold_%0d", k), {35'd0, dv[k], dxo[k], dyo[k], dco[k]}, {35'd0, 1'b1, prev_pix[k]});
        if (prev_done[k])
          chk($sformatf("busy_after_done_%0d", k), {63'd0, busy[k]}, 64'd0);
        if (dv[k] && wrk) begin
          if (k == 0) begin got_a.push_back({dxo[k], dyo[k], dco[k]}); st_a.push_back(cyc); end
          else begin got_b.push_back({dxo[k], dyo[k], dco[k]}); st_b.push_back(cyc); end
        end
        if (done[k]) done_cnt[k]++;
        if (ovr[k])  ovr_cnt[k]++;
        prev_stall[k] = dv[k] & ~wrk;
        prev_pix[k]   = {dxo[k], dyo[k], dco[k]};
        prev_done[k]  = done[k];
      end
    end
  end

  // Stall pattern for the small instance
  initial begin
    wr_b = 1'b1;
    forever begin
      @(posedge clk); #1;
      wr_b = rand_b ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  // Reference: rectangles in draw order, clipped against the window when CLIP_EN
  task automatic add_rect(input int x0, input int y0, input int w, input int h,
                          input logic [7:0] c, input bit clip,
                          input int bx0, input int bx1, input int by0, input int by1);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int ax, ay;
        bit keep;
        ax = x0 + x;
        ay = y0 + y;
        keep = 1'b1;
`ifdef CLIP_EN
        if (clip && (ax < bx0 || ax > bx1 || ay < by0 || ay > by1)) keep = 1'b0;
`endif
        if (keep) exp_q.push_back({10'(ax), 10'(ay), c});
      end
    end
  endtask

  task automatic build(input int bx0, input int bx1, input int by0, input int by1);
    exp_q.delete();
    add_rect(bu_in ? 10 : 11, 10, 1, 1, bu_in ? 8'h30 : 8'h0C, 1'b0, bx0, bx1, by0, by1);
    add_rect(bx0, by0, bx1 - bx0 + 1, by1 - by0 + 1, 8'h3F, 1'b0, bx0, bx1, by0, by1);
    for (int i = 0; i < 8; i++)
      if (pen_in[i]) add_rect(int'(px_in[i*10 +: 10]), int'(py_in[i*10 +: 10]), 11, 1, 8'h07, 1'b1, bx0, bx1, by0, by1);
    add_rect(int'(dx_in), int'(dy_in), 7, 9, 8'h2C, 1'b1, bx0, bx1, by0, by1);
  endtask

  task automatic rand_inputs();
    dx_in  = 10'($urandom_range(70, 105));
    dy_in  = 10'($urandom_range(0, 12));
    pen_in = 8'($urandom);
    bu_in  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 7; i++) begin
      px_in[i*10 +: 10] = 10'($urandom_range(70, 105));
      py_in[i*10 +: 10] = 10'($urandom_range(0, 10));
    end
    px_in[70 +: 10] = 10'($urandom_range(1015, 1023));
    py_in[70 +: 10] = 10'($urandom_range(0, 7));
  endtask

  task automatic pulse(input int k);
    @(posedge clk); #2;
    if (k == 0) fclk_a = 1'b1; else fclk_b = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    if (k == 0) fclk_a = 1'b0; else fclk_b = 1'b0;
  endtask

  task automatic clear(input int k);
    if (k == 0) begin got_a.delete(); st_a.delete(); end
    else begin got_b.delete(); st_b.delete(); end
    done_cnt[k] = 0;
    ovr_cnt[k]  = 0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    while (done_cnt[k] < 1 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("frame_done_in_budget_%0d", k), {63'd0, done_cnt[k] >= 1}, 64'd1);
    repeat (4) @(posedge clk);
  endtask

  task automatic cmp_seq(input int k, input string tag);
    logic [27:0] g[$];
    int bad;
    if (k == 0) g = got_a; else g = got_b;
    chk({tag, "_len"}, 64'(g.size()), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < g.size() && i < exp_q.size(); i++)
      if (bad == 0 && g[i] !== exp_q[i]) bad = i + 1;
    chk({tag, "_first_bad_idx_plus1"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int gap, nspr;
    rst_n = 1'b0; fclk_a = 1'b0; fclk_b = 1'b0; wr_a = 1'b1; rand_b = 1'b0;
    dx_in = 10'd100; dy_in = 10'd50; px_in = 80'd0; py_in = 80'd0; pen_in = 8'h01; bu_in = 1'b1;
    done_cnt[0] = 0; done_cnt[1] = 0; ovr_cnt[0] = 0; ovr_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_outputs_%0d", k),
          {32'd0, dv[k], busy[k], done[k], ovr[k], dxo[k], dyo[k], dco[k]}, 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Asynchronous reset in the middle of the background scan
    clear(0);
    pulse(0);
    repeat (300) @(posedge clk);
    chk("busy_mid_bg", {63'd0, busy[0]}, 64'd1);
    chk("bg_pixels_flowing", {63'd0, got_a.size() > 250}, 64'd1);
    #3; rst_n = 1'b0; #1;
    chk("async_reset_outputs", {32'd0, dv[0], busy[0], done[0], ovr[0], dxo[0], dyo[0], dco[0]}, 64'd0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    clear(0);
    repeat (60) @(posedge clk);
    chk("no_pixel_after_reset", 64'(got_a.size()), 64'd0);
    chk("idle_after_reset", {63'd0, busy[0]}, 64'd0);

    // Full default frame, with a second frame request landing during the background
    px_in[0 +: 10] = 10'd180; py_in[0 +: 10] = 10'd130;
    dx_in = 10'd100; dy_in = 10'd50; pen_in = 8'h01; bu_in = 1'b1;
    build(80, 239, 0, 239);
    clear(0);
    pulse(0);
    repeat (1000) @(posedge clk);
    pulse(0);
    wait_done(0, 50000);
    repeat (200) @(posedge clk);
    chk("total_transfers", 64'(got_a.size()), 64'd38475);
    chk("first_pixel", (got_a.size() > 0) ? 64'(got_a[0]) : 64'hDEAD, {36'd0, 10'd10, 10'd10, 8'h30});
    cmp_seq(0, "main_seq");
    chk("frame_done_once", 64'(done_cnt[0]), 64'd1);
    chk("overrun_once", 64'(ovr_cnt[0]), 64'd1);
    chk("no_second_frame", {63'd0, busy[0]}, 64'd0);
    if (st_a.size() > 38400) begin
      chk("buf_bg_single_bubble", 64'(st_a[1] - st_a[0]), 64'd2);
      chk("bg_no_bubbles", 64'(st_a[38400] - st_a[1]), 64'd38399);
    end else begin
      chk("stamps_present", 64'(st_a.size()), 64'd38475);
    end

    // Randomized stalls and inputs; inputs scrambled again mid-frame
    rand_b = 1'b1;
    for (int f = 0; f < 4; f++) begin
      rand_inputs();
      build(80, 95, 0, 7);
      clear(1);
      pulse(1);
      repeat (20) @(posedge clk);
      rand_inputs();
      wait_done(1, 5000);
      cmp_seq(1, $sformatf("rand_seq_%0d", f));
      chk($sformatf("rand_no_overrun_%0d", f), 64'(ovr_cnt[1]), 64'd0);
    end
    rand_b = 1'b0;

    // All platforms disabled: 8 dead PLAT cycles plus the sprite entry bubble
    pen_in = 8'h00; dx_in = 10'd82; dy_in = 10'd0; bu_in = 1'b0;
    build(80, 95, 0, 7);
    clear(1);
    repeat (2) @(posedge clk);
    pulse(1);
    wait_done(1, 5000);
    cmp_seq(1, "noplat_seq");
    gap = (st_b.size() > 129) ? (st_b[129] - st_b[128] - 1) : -1;
    chk("noplat_gap", 64'(gap), 64'd9);

    // Sprite straddling the window corner
    dx_in = 10'd92; dy_in = 10'd5;
    build(80, 95, 0, 7);
    clear(1);
    pulse(1);
    wait_done(1, 5000);
    cmp_seq(1, "clip_seq");
    nspr = got_b.size() - 129;
`ifdef CLIP_EN
    chk("clip_sprite_count", 64'(nspr), 64'd12);
`else
    chk("clip_sprite_count", 64'(nspr), 64'd63);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
